out_port_display: RTL

//  Downstream consumer of the pipelined CPU's out_port0: converts the 32-bit unsigned port value to BCD

---
 rtl/out_port_display_pkg.sv | 39 +++
 rtl/out_port_display_if.sv | 23 ++
 rtl/out_port_display_bin2bcd_seq.sv | 93 +++++++++
 rtl/out_port_display.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/out_port_display_pkg.sv
// Shared types and helpers for the out_port0 display path: converter FSM states,
// BCD sizing and the active-low 7-segment encoder.
package out_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // ceil(w * log10(2)) using a fixed-point log10(2) ~= 0.30103
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  localparam int BCD_DIGITS = bcd_digits(32);

  // Segments {g,f,e,d,c,b,a}, active-low; non-decimal nibbles show blank
  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/out_port_display_if.sv
// Value and display-pin bundle for out_port_display. The slave side is the
// display block; the master side is whoever supplies value_in and observes pins.
interface out_port_display_if #(
  parameter int DATA_W = 32,
  parameter int NDIG   = 8
);
  logic [DATA_W-1:0] value_in;
  logic [6:0]        seg_n;
  logic [NDIG-1:0]   an_n;
  logic [4*NDIG-1:0] bcd_out;
  logic              ovf;
  logic              busy;

  modport master (
    output value_in,
    input  seg_n, an_n, bcd_out, ovf, busy
  );

  modport slave (
    input  value_in,
    output seg_n, an_n, bcd_out, ovf, busy
  );
endinterface

// File: rtl/out_port_display_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter. One bit per cycle; the
// result in bcd is stable while done is high.
//
// state | meaning
// IDLE  | waiting for start; operands loaded on start
// CONV  | add-3 adjust and shift, one bit per cycle, until all DATA_W bits shifted
// DONE  | one cycle, accumulator holds the final BCD value
module bin2bcd_seq
  import out_disp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BCD_N  = bcd_digits(DATA_W)
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [DATA_W-1:0]    value,
  output logic                 busy,
  output logic                 done,
  output logic [4*BCD_N-1:0]   bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t                     state_q, state_d;
  logic [DATA_W-1:0]          shreg_q;
  logic [4*BCD_N-1:0]         acc_q, acc_adj;
  logic [4*BCD_N+DATA_W-1:0]  shifted;
  logic [CNT_W-1:0]           cnt_q;
  logic                       shift_done;

  assign shift_done = (cnt_q == CNT_W'(DATA_W));
  assign bcd        = acc_q;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONV;
      CONV:    if (shift_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Add 3 to every nibble >= 5, then shift the whole {acc, shreg} pair left
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < BCD_N; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    shifted = {acc_adj, shreg_q} << 1;
  end

  // Shift datapath: load on start, shift while bits remain
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q <= value;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        CONV: begin
          if (!shift_done) begin
            {acc_q, shreg_q} <= shifted;
            cnt_q            <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/out_port_display.sv
// out_port0 display: change-triggered BCD conversion, result latch and a
// multiplexed active-low 7-segment scanner.
// Build option LEADING_ZERO_BLANK_EN: blank zero digits above the most
// significant nonzero displayed digit (digit 0 always shown, not when ovf).
module out_port_display
  import out_disp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NDIG     = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clock,
  input  logic              resetn,
  out_port_display_if.slave port_if
);

  localparam int BCD_N  = bcd_digits(DATA_W);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [DATA_W-1:0]  last_val_q;
  logic               pending_q;
  logic               request;
  logic               start;
  logic               eng_busy;
  logic               eng_done;
  logic [4*BCD_N-1:0] eng_bcd;
  logic               upper_nz;
  logic [4*NDIG-1:0]  bcd_q;
  logic               ovf_q;
  logic [SCAN_W-1:0]  scan_cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               scan_on_q;
  logic               wrap;
  logic [3:0]         cur_nib;
  logic               blank;
  logic [6:0]         seg_d;
  logic [NDIG-1:0]    an_d;
  logic [6:0]         seg_q;
  logic [NDIG-1:0]    an_q;

  // A change seen while the engine is busy (including its DONE cycle) is
  // remembered in pending and served with whatever value_in is current then.
  assign request = (port_if.value_in != last_val_q);
  assign start   = !eng_busy && (request || pending_q);

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .BCD_N  (BCD_N)
  ) u_bin2bcd (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .value  (port_if.value_in),
    .busy   (eng_busy),
    .done   (eng_done),
    .bcd    (eng_bcd)
  );

  generate
    if (BCD_N > NDIG) begin : g_upper
      assign upper_nz = |eng_bcd[4*BCD_N-1:4*NDIG];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

  // Change detection and pending request
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_val_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      last_val_q <= port_if.value_in;
      pending_q  <= start ? 1'b0 : (pending_q | request);
    end
  end

  // Latch the finished conversion
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (eng_done) begin
      bcd_q <= eng_bcd[4*NDIG-1:0];
      ovf_q <= upper_nz;
    end
  end

  assign wrap = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));

  // Scan timer and digit index; the first wrap turns the display on at digit 0,
  // later wraps step to the next digit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      scan_on_q  <= 1'b0;
    end else begin
      scan_cnt_q <= wrap ? '0 : scan_cnt_q + 1'b1;
      if (wrap) begin
        if (!scan_on_q)                        scan_on_q <= 1'b1;
        else if (idx_q == IDX_W'(NDIG - 1))    idx_q     <= '0;
        else                                   idx_q     <= idx_q + 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd;

  // Highest displayed digit with a nonzero value (0 when all are zero)
  always_comb begin
    msd = '0;
    for (int i = 1; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = IDX_W'(i);
    end
  end

  assign blank = !ovf_q && (idx_q > msd);
`else
  assign blank = 1'b0;
`endif

  // Digit mux and segment encode for the selected digit
  always_comb begin
    cur_nib = bcd_q[int'(idx_q)*4 +: 4];
    seg_d   = blank ? SEG_BLANK : seg7_encode(cur_nib);
    an_d    = ~(NDIG'(1) << idx_q);
  end

  // Registered display pins, held dark until the first scan wrap
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else if (scan_on_q) begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign port_if.seg_n   = seg_q;
  assign port_if.an_n    = an_q;
  assign port_if.bcd_out = bcd_q;
  assign port_if.ovf     = ovf_q;
  assign port_if.busy    = eng_busy;

endmodule
